serial_sender_fifo: RTL and testbench

//   Parametrised next-generation serial frame transmitter for the ASIC-side link.

---
 rtl/serial_sender_fifo.sv | 230 +++++++++++++++++++++++
 tb/tb_serial_sender_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sender_fifo.sv
// serial_sender_fifo: FIFO-buffered one-wire frame transmitter (start bit, LSB-first data, zero gap).
// Optional even-parity bit between data and gap is built when SERIAL_SENDER_PARITY_EN is defined.
module serial_sender_fifo #(
  parameter int DATA_W   = 40,
  parameter int DEPTH    = 4,
  parameter int BIT_DIV  = 1,
  parameter int GAP_BITS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       sout,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int LVL_W   = $clog2(DEPTH+1);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int DIV_W   = $clog2(BIT_DIV+1);
  localparam int CNT_MAX = (DATA_W > GAP_BITS) ? DATA_W : GAP_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX+1);

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_EMPTY = LVL_W'(0);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV-1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W-1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS-1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_SENDER_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_GAP    = 3'd4
  } state_t;

`ifdef SERIAL_SENDER_PARITY_EN
  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction
`endif

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [LVL_W-1:0]  level_nxt_s;
  logic              in_ready_r;
  logic              sout_r;
  logic              busy_r;
  state_t            state_r;
  logic [DATA_W-1:0] shift_r;
  logic [DIV_W-1:0]  div_r;
  logic [CNT_W-1:0]  bit_r;
  logic [DATA_W-1:0] head_s;
  logic              push_s;
  logic              pop_s;
  logic              div_end_s;
  logic              gap_end_s;
`ifdef SERIAL_SENDER_PARITY_EN
  logic              par_r;
`endif

  assign in_ready   = in_ready_r;
  assign sout       = sout_r;
  assign busy       = busy_r;
  assign fifo_level = level_r;

  assign head_s    = mem_r[rd_ptr_r];
  assign div_end_s = (div_r == DIV_LAST);
  assign gap_end_s = (state_r == S_GAP) && div_end_s && (bit_r == GAP_LAST);
  // A full FIFO refuses the push even when a pop happens on the same edge.
  assign push_s    = in_valid && (level_r != LVL_FULL);

  // Pop decode: only from the registered level, when idle or at the last gap clock.
  always_comb begin
    pop_s = 1'b0;
    if (level_r == LVL_EMPTY) begin
      pop_s = 1'b0;
    end else if ((state_r == S_IDLE) || gap_end_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next level: push and pop together leave it unchanged.
  always_comb begin
    level_nxt_s = level_r;
    if (push_s && !pop_s) begin
      level_nxt_s = level_r + LVL_W'(1);
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - LVL_W'(1);
    end else begin
      level_nxt_s = level_r;
    end
  end

  // FIFO pointers, level and registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= LVL_EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      level_r    <= level_nxt_s;
      in_ready_r <= (level_nxt_s != LVL_FULL);
    end
  end

  // FIFO storage; contents are only meaningful below the level.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= in_data;
  end

  // Frame sequencer with registered serial output and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      shift_r <= {DATA_W{1'b0}};
      div_r   <= {DIV_W{1'b0}};
      bit_r   <= {CNT_W{1'b0}};
      sout_r  <= 1'b0;
      busy_r  <= 1'b0;
`ifdef SERIAL_SENDER_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            shift_r <= head_s;
`ifdef SERIAL_SENDER_PARITY_EN
            par_r   <= even_parity(head_s);
`endif
            div_r   <= {DIV_W{1'b0}};
            bit_r   <= {CNT_W{1'b0}};
            sout_r  <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= S_START;
          end
        end
        S_START: begin
          if (div_end_s) begin
            div_r   <= {DIV_W{1'b0}};
            bit_r   <= {CNT_W{1'b0}};
            sout_r  <= shift_r[0];
            shift_r <= shift_r >> 1;
            state_r <= S_DATA;
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        S_DATA: begin
          if (div_end_s) begin
            div_r <= {DIV_W{1'b0}};
            if (bit_r == DATA_LAST) begin
              bit_r   <= {CNT_W{1'b0}};
`ifdef SERIAL_SENDER_PARITY_EN
              sout_r  <= par_r;
              state_r <= S_PARITY;
`else
              sout_r  <= 1'b0;
              state_r <= S_GAP;
`endif
            end else begin
              bit_r   <= bit_r + CNT_W'(1);
              sout_r  <= shift_r[0];
              shift_r <= shift_r >> 1;
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
`ifdef SERIAL_SENDER_PARITY_EN
        S_PARITY: begin
          if (div_end_s) begin
            div_r   <= {DIV_W{1'b0}};
            bit_r   <= {CNT_W{1'b0}};
            sout_r  <= 1'b0;
            state_r <= S_GAP;
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
`endif
        S_GAP: begin
          if (div_end_s) begin
            div_r <= {DIV_W{1'b0}};
            if (bit_r == GAP_LAST) begin
              bit_r <= {CNT_W{1'b0}};
              // Back-to-back frames start straight from the last gap clock.
              if (pop_s) begin
                shift_r <= head_s;
`ifdef SERIAL_SENDER_PARITY_EN
                par_r   <= even_parity(head_s);
`endif
                sout_r  <= 1'b1;
                state_r <= S_START;
              end else begin
                sout_r  <= 1'b0;
                busy_r  <= 1'b0;
                state_r <= S_IDLE;
              end
            end else begin
              bit_r <= bit_r + CNT_W'(1);
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
          div_r   <= {DIV_W{1'b0}};
          bit_r   <= {CNT_W{1'b0}};
          sout_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sender_fifo.sv
// Bench for serial_sender_fifo: two instances (defaults, and BIT_DIV=3/GAP_BITS=2) checked every
// clock against a frame-timeline model, plus table vectors and directed corner sequences.
module tb_serial_sender_fifo;

  localparam int DW    = 40;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);
`ifdef SERIAL_SENDER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int BD0 = 1, GAP0 = 1, BD1 = 3, GAP1 = 2;
  localparam int FRAME0 = (1 + DW + GAP0 + PB) * BD0;
  localparam int FRAME1 = (1 + DW + GAP1 + PB) * BD1;
  localparam int MAXN = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0][DW-1:0] in_data;
  logic [1:0]         in_valid;
  wire  [1:0]         in_ready;
  wire  [1:0]         sout;
  wire  [1:0]         busy;
  wire  [1:0][LW-1:0] fifo_level;

  always #5 clk = ~clk;

  serial_sender_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .BIT_DIV(BD0), .GAP_BITS(GAP0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .sout(sout[0]), .busy(busy[0]), .fifo_level(fifo_level[0]));

  serial_sender_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .BIT_DIV(BD1), .GAP_BITS(GAP1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .sout(sout[1]), .busy(busy[1]), .fifo_level(fifo_level[1]));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: each accepted word has an accept edge and a frame-start edge.
  int              n_acc [2];
  int              acc_a [2][MAXN];
  int              st_a  [2][MAXN];
  logic [DW-1:0]   w_a   [2][MAXN];

  function automatic int bd_of(input int i);
    return (i == 0) ? BD0 : BD1;
  endfunction

  function automatic int fl_of(input int i);
    return (i == 0) ? FRAME0 : FRAME1;
  endfunction

  function automatic logic exp_sout(input int i, input int t);
    for (int k = 0; k < n_acc[i]; k++) begin
      if (t >= st_a[i][k] && t < st_a[i][k] + fl_of(i)) begin
        int j;
        j = (t - st_a[i][k]) / bd_of(i);
        if (j == 0) return 1'b1;
        if (j <= DW) return w_a[i][k][j-1];
        if (PB == 1 && j == DW + 1) return ^w_a[i][k];
        return 1'b0;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic exp_busy(input int i, input int t);
    for (int k = 0; k < n_acc[i]; k++)
      if (t >= st_a[i][k] && t < st_a[i][k] + fl_of(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_level(input int i, input int t);
    int c = 0;
    for (int k = 0; k < n_acc[i]; k++)
      if (acc_a[i][k] <= t && st_a[i][k] > t) c++;
    return c;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_accept();
    for (int i = 0; i < 2; i++) begin
      if (in_valid[i] && exp_level(i, cyc) < DEPTH && n_acc[i] < MAXN) begin
        int s;
        s = cyc + 2;
        if (n_acc[i] > 0 && st_a[i][n_acc[i]-1] + fl_of(i) > s) s = st_a[i][n_acc[i]-1] + fl_of(i);
        acc_a[i][n_acc[i]] = cyc + 1;
        st_a[i][n_acc[i]]  = s;
        w_a[i][n_acc[i]]   = in_data[i];
        n_acc[i]++;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("sout[%0d]@%0d", i, cyc), sout[i], exp_sout(i, cyc));
      chk($sformatf("busy[%0d]@%0d", i, cyc), busy[i], exp_busy(i, cyc));
      chk($sformatf("level[%0d]@%0d", i, cyc), fifo_level[i], exp_level(i, cyc));
      chk($sformatf("ready[%0d]@%0d", i, cyc), in_ready[i], (exp_level(i, cyc) < DEPTH) ? 1 : 0);
    end
  endtask

  task automatic tick();
    model_accept();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic model_clear();
    cyc = 0;
    n_acc[0] = 0;
    n_acc[1] = 0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int k = 0;
    while ((busy[i] || fifo_level[i] != LW'(0)) && k < budget) begin
      tick();
      k++;
    end
    chk($sformatf("drain[%0d]", i), (busy[i] == 1'b0 && fifo_level[i] == LW'(0)) ? 1 : 0, 1);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  typedef struct {
    logic [DW-1:0] data;
    logic [7:0]    first8;
    logic          par;
  } vec_t;

  vec_t vt [6];
  logic stream [64];

  initial begin
    int bc, peak, highs, n0;
    logic [DW-1:0] got;

    vt[0] = '{40'hD999999991, 8'h91, 1'b0};
    vt[1] = '{40'h0000000001, 8'h01, 1'b1};
    vt[2] = '{40'h0000000003, 8'h03, 1'b0};
    vt[3] = '{40'hFFFFFFFFFF, 8'hFF, 1'b0};
    vt[4] = '{40'h8000000000, 8'h00, 1'b1};
    vt[5] = '{40'hA5A5A5A5A5, 8'hA5, 1'b0};

    in_valid = 2'b00;
    in_data  = '0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    check_outputs();

    // Table vectors: one isolated frame each on the default instance.
    for (int v = 0; v < 6; v++) begin
      in_data[0]  = vt[v].data;
      in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      bc = 0;
      for (int k = 1; k <= FRAME0 + 1; k++) begin
        in_data[0] = rnd_word();
        tick();
        stream[k] = sout[0];
        if (busy[0]) bc++;
      end
      for (int b = 0; b < DW; b++) got[b] = stream[2 + b];
      chk($sformatf("vec%0d_start", v), stream[1], 1);
      chk($sformatf("vec%0d_data", v), got, vt[v].data);
      chk($sformatf("vec%0d_first8", v), got[7:0], vt[v].first8);
      chk($sformatf("vec%0d_parity_or_gap", v), stream[2 + DW], (PB == 1) ? vt[v].par : 1'b0);
      chk($sformatf("vec%0d_gap", v), stream[2 + DW + PB], 0);
      chk($sformatf("vec%0d_busy_clks", v), bc, 42 + PB);
    end

    // Three words on consecutive clocks: contiguous frames, level peaks at 2.
    wait_idle(0, 4 * FRAME0);
    bc = 0;
    peak = 0;
    for (int k = 0; k < 3 * FRAME0 + 8; k++) begin
      in_valid[0] = (k < 3) ? 1'b1 : 1'b0;
      in_data[0]  = rnd_word();
      tick();
      if (busy[0]) bc++;
      if (int'(fifo_level[0]) > peak) peak = int'(fifo_level[0]);
    end
    in_valid[0] = 1'b0;
    chk("burst3_peak_level", peak, 2);
    chk("burst3_busy_clks", bc, 3 * (42 + PB));

    // Valid held for seven words: five fit, then backpressure until pops free space.
    wait_idle(0, 4 * FRAME0);
    n0 = n_acc[0];
    in_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data[0] = rnd_word();
      tick();
    end
    chk("full_level", fifo_level[0], 4);
    chk("full_ready", in_ready[0], 0);
    chk("full_accepted", n_acc[0] - n0, 5);
    for (int k = 0; k < 6 * FRAME0 && (n_acc[0] - n0) < 7; k++) begin
      in_data[0] = rnd_word();
      tick();
    end
    in_valid[0] = 1'b0;
    chk("hold7_accepted", n_acc[0] - n0, 7);
    wait_idle(0, 10 * FRAME0);

    // Slow instance: BIT_DIV=3, GAP_BITS=2, single word.
    in_data[1]  = rnd_word();
    in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    bc = 0;
    for (int k = 0; k < FRAME1 + 6; k++) begin
      tick();
      if (busy[1]) bc++;
    end
    chk("slow_busy_clks", bc, (PB == 1) ? 132 : 129);

    // Reset at data bit 10 with two words queued.
    wait_idle(0, 4 * FRAME0);
    n0 = n_acc[0];
    for (int k = 0; k < 3; k++) begin
      in_data[0]  = rnd_word();
      in_valid[0] = 1'b1;
      tick();
    end
    in_valid[0] = 1'b0;
    for (int k = 0; k < 4 * FRAME0 && cyc < st_a[0][n0] + 11; k++) tick();
    chk("pre_reset_level", fifo_level[0], 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sout", sout[0], 0);
    chk("async_rst_busy", busy[0], 0);
    chk("async_rst_level", fifo_level[0], 0);
    chk("async_rst_ready", in_ready[0], 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    check_outputs();
    highs = 0;
    for (int k = 0; k < 2 * FRAME0; k++) begin
      tick();
      if (sout[0]) highs++;
    end
    chk("post_reset_no_frame", highs, 0);

    // Randomized traffic on both instances at several load levels.
    for (int ph = 0; ph < 3; ph++) begin
      for (int k = 0; k < 1000; k++) begin
        for (int i = 0; i < 2; i++) begin
          in_valid[i] = ($urandom_range(0, 99) < (ph * 40 + 10)) ? 1'b1 : 1'b0;
          in_data[i]  = rnd_word();
        end
        tick();
      end
    end
    in_valid = 2'b00;
    wait_idle(0, 10 * FRAME0);
    wait_idle(1, 10 * FRAME1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
